// File: rtl/if_fetch_buffer_pkg.sv
// Shared widths, encodings and types for the IF/ID fetch buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_fetch_buffer_pkg;

  localparam int IfbDepth    = 4;
  localparam int IfbAddrW    = 2;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  // ctrl stall vector bit encodings
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // branch_flag encoding, reused for flush_i
  localparam logic Branch = 1'b1;

  // one fetched (pc, inst) pair as stored in the queue
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_pair_t;

  // where the ID register takes its next instruction from
  typedef enum logic [1:0] {
    SRC_BUBBLE = 2'd0,
    SRC_HEAD   = 2'd1,
    SRC_BYPASS = 2'd2
  } id_src_e;

  function automatic fetch_pair_t make_pair(input logic [InstAddrBus-1:0] pc,
                                            input logic [InstBus-1:0]     inst);
    fetch_pair_t p;
    p.pc   = pc;
    p.inst = inst;
    return p;
  endfunction

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Fetch-side / ID-side signal bundle of the fetch buffer.
// Latency: n/a (wiring only).
// Backpressure: stallreq_o tells ctrl to stop IF when the queue is full.
// Ports: master = PC stage / ctrl / ID environment, slave = the fetch buffer.
interface if_fetch_buffer_if
  import if_fetch_buffer_pkg::*;
  ();

  logic [5:0]             stall;
  logic [InstAddrBus-1:0] pc_i;
  logic                   ce_i;
  logic [InstBus-1:0]     inst_i;
  logic                   flush_i;
  logic [InstAddrBus-1:0] id_pc;
  logic [InstBus-1:0]     id_inst;
  logic                   id_valid;
  logic                   stallreq_o;

  modport master (
    output stall, pc_i, ce_i, inst_i, flush_i,
    input  id_pc, id_inst, id_valid, stallreq_o
  );

  modport slave (
    input  stall, pc_i, ce_i, inst_i, flush_i,
    output id_pc, id_inst, id_valid, stallreq_o
  );

endinterface

// File: rtl/if_fetch_buffer_fifo.sv
// DEPTH x 64-bit (pc, inst) queue with push/pop, full clear and truncate-to-head.
// Latency: write visible at rd_dat the cycle after push; rd_dat is combinational from rd_ptr.
// Backpressure: a push while full is accepted only alongside a pop, otherwise dropped.
// Ports: clk/rst; push/pop/clear/trunc controls; wr_dat in, rd_dat out; count/full/empty status.
module if_fetch_buffer_fifo
  import if_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = IfbDepth,
  parameter int ADDR_W = IfbAddrW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic          trunc,
  input  fetch_pair_t   wr_dat,
  output fetch_pair_t   rd_dat,
  output logic [ADDR_W:0] count,
  output logic          full,
  output logic          empty
);

  localparam int CNT_W = ADDR_W + 1;

  fetch_pair_t       mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              do_pop;
  logic              do_push;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];

  // clear and trunc take precedence over normal traffic
  assign do_pop  = pop & ~empty & ~clear & ~trunc;
  assign do_push = push & ~clear & ~trunc & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (trunc) begin
      // keep only the head entry, if there is one
      wr_ptr <= rd_ptr + ADDR_W'(!empty);
      count  <= CNT_W'(!empty);
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // storage needs no reset: entries are only read when count says they are valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// IF/ID prefetch queue plus ID pipeline register with branch-delay-slot flush.
// Latency: 1 cycle fetch-to-ID through the bypass when the queue is empty, else FIFO order.
// Backpressure: stallreq_o high while the queue holds DEPTH entries; pushes are held off by stall[0].
// Ports: clk, rst (sync, active-low); bus.slave carries stall/pc_i/ce_i/inst_i/flush_i in
//        and id_pc/id_inst/id_valid/stallreq_o out.
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = IfbDepth,
  parameter int ADDR_W = IfbAddrW
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_buffer_if.slave  bus
);

  logic                   push;
  logic                   take;
  logic                   flush;
  logic                   bad_flush;
  id_src_e                src;
  logic                   head_used;
  logic                   bypass_used;

  fetch_pair_t            fifo_rd_dat;
  logic [ADDR_W:0]        fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic [InstAddrBus-1:0] nxt_pc;
  logic [InstBus-1:0]     nxt_inst;
  logic                   nxt_valid;

  logic [InstAddrBus-1:0] id_pc_q;
  logic [InstBus-1:0]     id_inst_q;
  logic                   id_valid_q;

  logic                   unused_stall_hi;
  assign unused_stall_hi = ^bus.stall[5:3];

  // push marks the cycle the PC stage advances, so each pair is consumed once
  assign push      = bus.ce_i & (bus.stall[0] == NoStop);
  assign take      = (bus.stall[1] == NoStop);
  assign flush     = take & (bus.flush_i == Branch);
  // a flush while ID is stopped is not legal; it only trims the queue to its head
  assign bad_flush = ~take & (bus.flush_i == Branch);

  // oldest instruction wins: queue head, then the live fetch, then a bubble
  always_comb begin
    src = SRC_BUBBLE;
    if (!fifo_empty) begin
      src = SRC_HEAD;
    end else if (push) begin
      src = SRC_BYPASS;
    end
  end

  assign head_used   = take & (src == SRC_HEAD);
  assign bypass_used = take & (src == SRC_BYPASS);

  always_comb begin
    nxt_pc    = ZeroWord;
    nxt_inst  = ZeroWord;
    nxt_valid = 1'b0;
    case (src)
      SRC_HEAD: begin
        nxt_pc    = fifo_rd_dat.pc;
        nxt_inst  = fifo_rd_dat.inst;
        nxt_valid = 1'b1;
      end
      SRC_BYPASS: begin
        nxt_pc    = bus.pc_i;
        nxt_inst  = bus.inst_i;
        nxt_valid = 1'b1;
      end
      default: begin
        nxt_pc    = ZeroWord;
        nxt_inst  = ZeroWord;
        nxt_valid = 1'b0;
      end
    endcase
  end

  // On flush the clear wipes everything left behind the delay slot, including
  // pc_i when the head was the delay slot. A bypassed pc_i is never also queued.
  if_fetch_buffer_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ifb_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push & ~bypass_used & ~flush),
    .pop    (head_used & ~flush),
    .clear  (flush),
    .trunc  (bad_flush),
    .wr_dat (make_pair(bus.pc_i, bus.inst_i)),
    .rd_dat (fifo_rd_dat),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // ID register: load when ID runs; bubble when only ID is stopped; hold when EX is stopped too
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_pc_q    <= ZeroWord;
      id_inst_q  <= ZeroWord;
      id_valid_q <= 1'b0;
    end else if (take) begin
      id_pc_q    <= nxt_pc;
      id_inst_q  <= nxt_inst;
      id_valid_q <= nxt_valid;
    end else if (bus.stall[2] == NoStop) begin
      id_pc_q    <= ZeroWord;
      id_inst_q  <= ZeroWord;
      id_valid_q <= 1'b0;
    end
  end

  assign bus.id_pc      = id_pc_q;
  assign bus.id_inst    = id_inst_q;
  assign bus.id_valid   = id_valid_q;
  assign bus.stallreq_o = fifo_full;

endmodule
